// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract sequencer that drives an external 4-bit adder one
// digit per cycle. It accumulates the W-bit result, the final carry and the signed overflow.
module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4,
   localparam int W = 4 * NIBBLES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         c_in,
   input  logic         sub,
   input  logic         sel,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         c_out,
   output logic         ovf,
   output logic [3:0]   add_a,
   output logic [3:0]   add_b,
   output logic         add_c_in,
   output logic         add_sel,
   input  logic [3:0]   add_s,
   input  logic         add_c_out,
   output logic [1:0]   dbg_state
);

   localparam int IW = $clog2(NIBBLES);
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Handshake: start is sampled only in IDLE; a request seen while busy is
   // dropped entirely, and done pulses for exactly one cycle after the last nibble.
   logic [1:0]    state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic          carry_q, carry_d;
   logic          sel_q, sel_d;
   logic [W-1:0]  result_q, result_d;
   logic          c_out_q, c_out_d;
   logic          ovf_q, ovf_d;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      sel_d    = sel_q;
      result_d = result_q;
      c_out_d  = c_out_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d      = op_a;
               // Subtraction as a + ~b + 1: invert here, seed the carry with 1.
               b_d      = sub ? ~op_b : op_b;
               carry_d  = sub ? 1'b1 : c_in;
               sel_d    = sel;
               result_d = '0;
               idx_d    = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            result_d[{idx_q, 2'b00} +: 4] = add_s;
            carry_d = add_c_out;
            idx_d   = idx_q + IW'(1);
            if (idx_q == LAST) begin
               c_out_d = add_c_out;
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_s[3] != a_q[W-1]);
               idx_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         sel_q    <= 1'b0;
         result_q <= '0;
         c_out_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         carry_q  <= carry_d;
         sel_q    <= sel_d;
         result_q <= result_d;
         c_out_q  <= c_out_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      add_a    = 4'h0;
      add_b    = 4'h0;
      add_c_in = 1'b0;
      if (state_q == S_RUN) begin
         add_a    = a_q[{idx_q, 2'b00} +: 4];
         add_b    = b_q[{idx_q, 2'b00} +: 4];
         add_c_in = carry_q;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign result    = result_q;
   assign c_out     = c_out_q;
   assign ovf       = ovf_q;
   assign add_sel   = sel_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl. It models the external 4-bit adder
// and checks results, latency, handshake and reset against hand-computed vectors.
module tb_nibble_serial_adder_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] op_a, op_b;
   logic        c_in, sub, sel;
   logic        busy, done;
   logic [15:0] result;
   logic        c_out, ovf;
   logic [3:0]  add_a, add_b, add_s;
   logic        add_c_in, add_sel, add_c_out;
   logic [1:0]  dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
      .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
      .c_in(c_in), .sub(sub), .sel(sel), .busy(busy), .done(done),
      .result(result), .c_out(c_out), .ovf(ovf), .add_a(add_a), .add_b(add_b),
      .add_c_in(add_c_in), .add_sel(add_sel), .add_s(add_s),
      .add_c_out(add_c_out), .dbg_state(dbg_state)
   );

   // Clock / reset block
   always #5 clk = ~clk;

   // External adder model: sel picks a direct sum or a bitwise ripple chain.
   always_comb begin
      logic c;
      add_s     = 4'h0;
      add_c_out = 1'b0;
      if (add_sel) begin
         c = add_c_in;
         for (int i = 0; i < 4; i++) begin
            add_s[i] = add_a[i] ^ add_b[i] ^ c;
            c = (add_a[i] & add_b[i]) | (c & (add_a[i] ^ add_b[i]));
         end
         add_c_out = c;
      end else begin
         {add_c_out, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_c_in);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".busy"}, 32'(busy), 32'd0);
      check({tag, ".done"}, 32'(done), 32'd0);
      check({tag, ".result"}, 32'(result), 32'd0);
      check({tag, ".c_out"}, 32'(c_out), 32'd0);
      check({tag, ".ovf"}, 32'(ovf), 32'd0);
      check({tag, ".add_bus"}, {23'd0, add_sel, add_c_in, add_a, add_b}, 32'd0);
   endtask

   // Driver: one operation, observed over a fixed 10-cycle window after accept.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic s, input logic sl, input bit repulse,
                         input bit chk_cin, input logic [15:0] er, input logic ec,
                         input logic eo);
      int lat, done_n, busy_n, cin_bad, sel_bad;
      @(negedge clk);
      op_a = a; op_b = b; c_in = ci; sub = s; sel = sl; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; op_a = 16'h0; op_b = 16'h0; c_in = 1'b0; sub = 1'b0;
      lat = 0; done_n = 0; busy_n = 0; cin_bad = 0; sel_bad = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (lat == 0) lat = i;
         end
         if (busy && !done && add_c_in !== 1'b1) cin_bad++;
         if (add_sel !== sl) sel_bad++;
         if (repulse && i == 2) begin
            start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555;
         end else begin
            start = 1'b0;
         end
      end
      check({tag, ".result"}, 32'(result), 32'(er));
      check({tag, ".c_out"}, 32'(c_out), 32'(ec));
      check({tag, ".ovf"}, 32'(ovf), 32'(eo));
      check({tag, ".latency"}, 32'(lat), 32'd5);
      check({tag, ".busy_cycles"}, 32'(busy_n), 32'd5);
      check({tag, ".done_pulses"}, 32'(done_n), 32'd1);
      check({tag, ".add_sel"}, 32'(sel_bad), 32'd0);
      check({tag, ".idle_add_a"}, 32'(add_a), 32'd0);
      if (chk_cin) check({tag, ".add_c_in_run"}, 32'(cin_bad), 32'd0);
   endtask

   initial begin
      int done_seen;
      rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; c_in = 1'b0; sub = 1'b0; sel = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      run_op("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_op("add_ffff_cin",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      run_op("sub_5_7",       16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      run_op("sub_8000_1",    16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      run_op("add_7fff_1",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("repulse",       16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3333, 1'b0, 1'b0);
      run_op("sel1_sub",      16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      run_op("sel1_add",      16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

      // Mid-RUN reset: assert in the second RUN cycle, away from any clock edge.
      @(negedge clk);
      op_a = 16'h0F0F; op_b = 16'h0101; sel = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 check_all_zero("midrun_rst");
      done_seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("midrun_rst.no_done", 32'(done_seen), 32'd0);
      run_op("post_rst_add", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
